// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: passes ALU ops to WB in 1 cycle, runs one data-memory access at a time, and flags ERR on an ack timeout.
// Backpressure: stall_out is high whenever the FSM is not IDLE; halt blocks capture in IDLE only.
module mem_stage_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic [15:0] write_back_ctrl_sgnl,
   input  logic [15:0] memory_ctrl_sgnl,
   input  logic [15:0] alu_result_top_half,
   input  logic [15:0] alu_result_bottom_half,
   input  logic [15:0] inst_buff_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_byte,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] write_back_ctrl_sgnl_out,
   output logic [15:0] alu_result_top_half_out,
   output logic [15:0] alu_result_bottom_half_out,
   output logic [15:0] mem_data_out,
   output logic [15:0] inst_buff_out,
   output logic        valid_out,
   output logic        stall_out,
   output logic        err_out
);

   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [15:0] cap_wb;
   logic [15:0] cap_inst;
   logic        is_mem_op;
   logic        expire;
   logic        ctrl_unused;

   assign ctrl_unused = ^memory_ctrl_sgnl[15:3];
   assign is_mem_op   = memory_ctrl_sgnl[0] | memory_ctrl_sgnl[1];
   assign expire      = !mem_ack && (cnt == CNT_LAST);
   assign stall_out   = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!halt && is_mem_op) state_nxt = BUSY;
         BUSY: begin
            if (mem_ack)     state_nxt = IDLE;
            else if (expire) state_nxt = ERR;
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_addr/mem_wdata double as the captured address and store data for the WB hand-off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt                        <= 4'd0;
         cap_wb                     <= 16'd0;
         cap_inst                   <= 16'd0;
         mem_req                    <= 1'b0;
         mem_we                     <= 1'b0;
         mem_byte                   <= 1'b0;
         mem_addr                   <= 16'd0;
         mem_wdata                  <= 16'd0;
         write_back_ctrl_sgnl_out   <= 16'd0;
         alu_result_top_half_out    <= 16'd0;
         alu_result_bottom_half_out <= 16'd0;
         mem_data_out               <= 16'd0;
         inst_buff_out              <= 16'd0;
         valid_out                  <= 1'b0;
         err_out                    <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (!halt) begin
                  if (is_mem_op) begin
                     cnt       <= 4'd0;
                     cap_wb    <= write_back_ctrl_sgnl;
                     cap_inst  <= inst_buff_in;
                     mem_req   <= 1'b1;
                     mem_we    <= memory_ctrl_sgnl[1];
                     mem_byte  <= memory_ctrl_sgnl[2];
                     mem_addr  <= alu_result_bottom_half;
                     mem_wdata <= alu_result_top_half;
                  end else begin
                     write_back_ctrl_sgnl_out   <= write_back_ctrl_sgnl;
                     alu_result_top_half_out    <= alu_result_top_half;
                     alu_result_bottom_half_out <= alu_result_bottom_half;
                     inst_buff_out              <= inst_buff_in;
                     mem_data_out               <= 16'd0;
                     valid_out                  <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req                    <= 1'b0;
                  write_back_ctrl_sgnl_out   <= cap_wb;
                  alu_result_top_half_out    <= mem_wdata;
                  alu_result_bottom_half_out <= mem_addr;
                  inst_buff_out              <= cap_inst;
                  valid_out                  <= 1'b1;
                  if (mem_we)        mem_data_out <= 16'd0;
                  else if (mem_byte) mem_data_out <= {{8{mem_rdata[7]}}, mem_rdata[7:0]};
                  else               mem_data_out <= mem_rdata;
               end else if (expire) begin
                  mem_req <= 1'b0;
                  err_out <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, halt, byte/word reads, write, timeout and async reset.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        halt;
   logic [15:0] wb_in, mctrl, top, bot, inst;
   logic        mem_req, mem_we, mem_byte;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic [15:0] wb_out, top_out, bot_out, mdata_out, inst_out;
   logic        valid_out, stall_out, err_out;

   int vectors = 0;
   int miscompares = 0;

   mem_stage_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .halt(halt),
      .write_back_ctrl_sgnl(wb_in), .memory_ctrl_sgnl(mctrl),
      .alu_result_top_half(top), .alu_result_bottom_half(bot),
      .inst_buff_in(inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .write_back_ctrl_sgnl_out(wb_out), .alu_result_top_half_out(top_out),
      .alu_result_bottom_half_out(bot_out), .mem_data_out(mdata_out),
      .inst_buff_out(inst_out), .valid_out(valid_out),
      .stall_out(stall_out), .err_out(err_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},   16'(mem_req),   16'd0);
      chk({tag, "_stall"}, 16'(stall_out), 16'd0);
      chk({tag, "_err"},   16'(err_out),   16'd0);
      chk({tag, "_valid"}, 16'(valid_out), 16'd0);
      chk({tag, "_addr"},  mem_addr,       16'd0);
      chk({tag, "_wdata"}, mem_wdata,      16'd0);
      chk({tag, "_we"},    16'(mem_we),    16'd0);
      chk({tag, "_bot"},   bot_out,        16'd0);
      chk({tag, "_mdata"}, mdata_out,      16'd0);
      chk({tag, "_inst"},  inst_out,       16'd0);
   endtask

   initial begin
      rst = 1'b0; halt = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
      wb_in = 16'h1111; mctrl = 16'h0000; top = 16'h2222; bot = 16'hDDDD; inst = 16'hAAAA;
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // ALU op pass-through
      step();
      chk("alu_bot",   bot_out,          16'hDDDD);
      chk("alu_inst",  inst_out,         16'hAAAA);
      chk("alu_top",   top_out,          16'h2222);
      chk("alu_wb",    wb_out,           16'h1111);
      chk("alu_mdata", mdata_out,        16'h0000);
      chk("alu_valid", 16'(valid_out),   16'd1);
      chk("alu_req",   16'(mem_req),     16'd0);

      // halt in IDLE: nothing captured, valid pulse ends, stray ack ignored
      halt = 1'b1; top = 16'h1234; bot = 16'h4561; mctrl = 16'h0001; mem_ack = 1'b1;
      step();
      chk("halt_valid", 16'(valid_out), 16'd0);
      chk("halt_bot",   bot_out,        16'hDDDD);
      chk("halt_top",   top_out,        16'h2222);
      chk("halt_req",   16'(mem_req),   16'd0);
      chk("halt_stall", 16'(stall_out), 16'd0);

      // byte read, ack on the 4th BUSY edge
      halt = 1'b0; mem_ack = 1'b0; mctrl = 16'h0005; bot = 16'h0040; top = 16'h5555;
      inst = 16'h0BBB; wb_in = 16'h0C0C; mem_rdata = 16'h12F0;
      step();
      chk("br_req",   16'(mem_req),   16'd1);
      chk("br_addr",  mem_addr,       16'h0040);
      chk("br_byte",  16'(mem_byte),  16'd1);
      chk("br_we",    16'(mem_we),    16'd0);
      chk("br_valid", 16'(valid_out), 16'd0);
      chk("br_stall", 16'(stall_out), 16'd1);
      bot = 16'h9999; halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("br_hold_addr",  mem_addr,       16'h0040);
         chk("br_hold_stall", 16'(stall_out), 16'd1);
         chk("br_hold_req",   16'(mem_req),   16'd1);
      end
      mem_ack = 1'b1;
      step();
      chk("br_done_mdata", mdata_out,        16'hFFF0);
      chk("br_done_valid", 16'(valid_out),   16'd1);
      chk("br_done_stall", 16'(stall_out),   16'd0);
      chk("br_done_req",   16'(mem_req),     16'd0);
      chk("br_done_bot",   bot_out,          16'h0040);
      chk("br_done_top",   top_out,          16'h5555);
      chk("br_done_inst",  inst_out,         16'h0BBB);
      chk("br_done_wb",    wb_out,           16'h0C0C);
      mem_ack = 1'b0;
      step();
      chk("br_pulse", 16'(valid_out), 16'd0);
      chk("br_mdata_hold", mdata_out, 16'hFFF0);

      // write with both read and write bits set, ack after one cycle
      halt = 1'b0; mctrl = 16'h0003; top = 16'hBEEF; bot = 16'h0010; inst = 16'h3333; wb_in = 16'h4444;
      step();
      chk("wr_we",    16'(mem_we),  16'd1);
      chk("wr_wdata", mem_wdata,    16'hBEEF);
      chk("wr_addr",  mem_addr,     16'h0010);
      chk("wr_req",   16'(mem_req), 16'd1);
      mem_ack = 1'b1; mem_rdata = 16'h7777; halt = 1'b1;
      step();
      chk("wr_mdata", mdata_out,        16'h0000);
      chk("wr_valid", 16'(valid_out),   16'd1);
      chk("wr_stall", 16'(stall_out),   16'd0);
      chk("wr_top",   top_out,          16'hBEEF);
      chk("wr_inst",  inst_out,         16'h3333);

      // word read, immediate ack
      mem_ack = 1'b0; halt = 1'b0; mctrl = 16'h0001; bot = 16'h0020;
      step();
      chk("rd_we", 16'(mem_we), 16'd0);
      mem_ack = 1'b1; mem_rdata = 16'h8081; halt = 1'b1;
      step();
      chk("rd_mdata", mdata_out,      16'h8081);
      chk("rd_bot",   bot_out,        16'h0020);
      chk("rd_valid", 16'(valid_out), 16'd1);

      // timeout: ack never comes
      mem_ack = 1'b0; halt = 1'b0; mctrl = 16'h0001; bot = 16'h0030;
      step();
      halt = 1'b1;
      for (int i = 0; i < 15; i++) step();
      chk("to_pre_err", 16'(err_out), 16'd0);
      chk("to_pre_req", 16'(mem_req), 16'd1);
      step();
      chk("to_err",   16'(err_out),   16'd1);
      chk("to_req",   16'(mem_req),   16'd0);
      chk("to_stall", 16'(stall_out), 16'd1);
      mem_ack = 1'b1; halt = 1'b0; mctrl = 16'h0000;
      for (int i = 0; i < 3; i++) step();
      chk("to_late_err",   16'(err_out),   16'd1);
      chk("to_late_stall", 16'(stall_out), 16'd1);
      chk("to_late_valid", 16'(valid_out), 16'd0);
      chk("to_late_bot",   bot_out,        16'h0020);

      // async reset out of ERR, then first capture on the first edge
      #2 rst = 1'b0; mem_ack = 1'b0;
      #1;
      chk("rst_err",   16'(err_out),   16'd0);
      chk("rst_stall", 16'(stall_out), 16'd0);
      @(negedge clk);
      rst = 1'b1; halt = 1'b0; mctrl = 16'h0000; inst = 16'h5A5A; bot = 16'h0101;
      step();
      chk("first_valid", 16'(valid_out), 16'd1);
      chk("first_inst",  inst_out,       16'h5A5A);

      // async reset mid-BUSY
      mctrl = 16'h0001; bot = 16'h0050;
      step();
      chk("mb_req", 16'(mem_req), 16'd1);
      #2 rst = 1'b0;
      #1;
      chk_all_zero("mb_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
